// File: rtl/pixel_l1_hit_buffer.sv
// Per-pixel L1 readout: circular buffer of per-crossing TDC results, L1A lookup,
// event tagging and a show-ahead output FIFO with saturating overflow accounting.
module pixel_l1_hit_buffer #(
    parameter int unsigned L1ADDRWIDTH   = 7,
    parameter int unsigned DATAWIDTH     = 29,
    parameter int unsigned PIXIDWIDTH    = 8,
    parameter int unsigned EVTWIDTH      = 8,
    parameter int unsigned FIFOADDRWIDTH = 2
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic [L1ADDRWIDTH-1:0]                    L1ADelay,
    input  logic [PIXIDWIDTH-1:0]                     pixelID,
    input  logic                                      disDataReadout,
    input  logic                                      hitIn,
    input  logic [DATAWIDTH-1:0]                      TDCData,
    input  logic                                      L1A,
    input  logic                                      dnRead,
    output logic                                      dnValid,
    output logic [EVTWIDTH+PIXIDWIDTH+DATAWIDTH-1:0]  dnData,
    output logic                                      fifoFull,
    output logic [7:0]                                ovfCount
);

    localparam int unsigned CBDEPTH   = 2 ** L1ADDRWIDTH;
    localparam int unsigned FIFODEPTH = 2 ** FIFOADDRWIDTH;
    localparam int unsigned WORDWIDTH = EVTWIDTH + PIXIDWIDTH + DATAWIDTH;
    localparam int unsigned OCCWIDTH  = FIFOADDRWIDTH + 1;

    // Circular buffer: data array carries no reset, hit flags do
    logic [DATAWIDTH-1:0]   cbData [CBDEPTH];
    logic [CBDEPTH-1:0]     cbHit;
    logic [L1ADDRWIDTH-1:0] wrPtr;
    logic [L1ADDRWIDTH-1:0] rdAddr;
    logic [EVTWIDTH-1:0]    evtCnt;

    // Stage 1 holds the CB lookup, stage 2 the assembled push word
    logic                   s1Hit;
    logic [EVTWIDTH-1:0]    s1Evt;
    logic [DATAWIDTH-1:0]   s1Data;
    logic                   s2Push;
    logic [WORDWIDTH-1:0]   s2Word;

    logic [WORDWIDTH-1:0]     fifoMem [FIFODEPTH];
    logic [FIFOADDRWIDTH-1:0] fifoRd;
    logic [FIFOADDRWIDTH-1:0] fifoWr;
    logic [OCCWIDTH-1:0]      occ;

    logic                     doPop;
    logic                     doPush;
    logic                     doDrop;
    logic                     isFull;
    logic [FIFOADDRWIDTH-1:0] rdNext;
    logic [OCCWIDTH-1:0]      occPop;
    logic [OCCWIDTH-1:0]      occNext;
    logic [WORDWIDTH-1:0]     headNext;

    // Delay 0 aliases the slot about to be overwritten, i.e. the oldest entry
    assign rdAddr = wrPtr - L1ADelay;

    always_ff @(posedge clk) begin
        cbData[wrPtr] <= TDCData;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr  <= '0;
            cbHit  <= '0;
            evtCnt <= '0;
            s1Hit  <= 1'b0;
            s1Evt  <= '0;
            s2Push <= 1'b0;
        end else begin
            wrPtr        <= wrPtr + L1ADDRWIDTH'(1);
            cbHit[wrPtr] <= hitIn;
            s1Hit        <= L1A & cbHit[rdAddr];
            s2Push       <= s1Hit & ~disDataReadout;
            if (L1A) begin
                evtCnt <= evtCnt + EVTWIDTH'(1);
                s1Evt  <= evtCnt;
            end
        end
    end

    // Payload registers are qualified by the reset valid bits above
    always_ff @(posedge clk) begin
        if (L1A) begin
            s1Data <= cbData[rdAddr];
        end
        s2Word <= {s1Evt, pixelID, s1Data};
    end

    // FIFO next-state: pop frees a slot for a same-cycle push when full
    always_comb begin
        isFull   = (occ == OCCWIDTH'(FIFODEPTH));
        doPop    = dnRead && (occ != '0);
        doPush   = s2Push && (!isFull || doPop);
        doDrop   = s2Push && isFull && !doPop;
        rdNext   = fifoRd + FIFOADDRWIDTH'(doPop);
        occPop   = occ - OCCWIDTH'(doPop);
        occNext  = occPop + OCCWIDTH'(doPush);
        headNext = dnData;
        if (occNext != '0) begin
            headNext = (occPop == '0) ? s2Word : fifoMem[rdNext];
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[fifoWr] <= s2Word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifoRd   <= '0;
            fifoWr   <= '0;
            occ      <= '0;
            dnValid  <= 1'b0;
            fifoFull <= 1'b0;
            dnData   <= '0;
            ovfCount <= '0;
        end else begin
            fifoRd   <= rdNext;
            occ      <= occNext;
            dnValid  <= (occNext != '0);
            fifoFull <= (occNext == OCCWIDTH'(FIFODEPTH));
            dnData   <= headNext;
            if (doPush) begin
                fifoWr <= fifoWr + FIFOADDRWIDTH'(1);
            end
            if (doDrop && (ovfCount != 8'hFF)) begin
                ovfCount <= ovfCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_l1_hit_buffer.sv
// Directed bench for pixel_l1_hit_buffer: latency, event tagging, CB wrap,
// FIFO full/drop/bypass, async reset and readout disable.
module tb_pixel_l1_hit_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [6:0]  L1ADelay;
    logic [7:0]  pixelID;
    logic        disDataReadout;
    logic        hitIn;
    logic [28:0] TDCData;
    logic        L1A;
    logic        dnRead;
    logic        dnValid;
    logic [44:0] dnData;
    logic        fifoFull;
    logic [7:0]  ovfCount;

    int checks = 0;
    int errors = 0;

    pixel_l1_hit_buffer dut (
        .clk            (clk),
        .rstn           (rstn),
        .L1ADelay       (L1ADelay),
        .pixelID        (pixelID),
        .disDataReadout (disDataReadout),
        .hitIn          (hitIn),
        .TDCData        (TDCData),
        .L1A            (L1A),
        .dnRead         (dnRead),
        .dnValid        (dnValid),
        .dnData         (dnData),
        .fifoFull       (fifoFull),
        .ovfCount       (ovfCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] word(input int evt, input logic [28:0] data);
        logic [7:0] e;
        e = 8'(evt);
        return 64'({e, 8'h5A, data});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs cycles first..last; hit/L1A asserted inside their index windows
    task automatic seq(input int first, input int last, input int hitLo, input int hitHi,
                       input int l1aLo, input int l1aHi, input logic [28:0] base);
        for (int i = first; i <= last; i++) begin
            hitIn   = (i >= hitLo) && (i <= hitHi);
            TDCData = hitIn ? base + 29'(i - hitLo) : 29'(i * 7);
            L1A     = (i >= l1aLo) && (i <= l1aHi);
            @(posedge clk);
            #1;
        end
        hitIn = 1'b0;
        L1A   = 1'b0;
    endtask

    task automatic doReset();
        rstn    = 1'b0;
        hitIn   = 1'b0;
        L1A     = 1'b0;
        dnRead  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; hitIn = 1'b0; TDCData = '0; L1A = 1'b0; dnRead = 1'b0;
        disDataReadout = 1'b0; L1ADelay = 7'd20; pixelID = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dnValid", 64'(dnValid), 64'd0);
        check("rst_fifoFull", 64'(fifoFull), 64'd0);
        check("rst_ovf", 64'(ovfCount), 64'd0);
        check("rst_dnData", 64'(dnData), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic hit recovery and two-edge latency
        seq(0, 31, 10, 10, 30, 30, 29'h0ABCDEF);
        check("t1_not_yet", 64'(dnValid), 64'd0);
        seq(32, 32, -1, -1, -1, -1, '0);
        check("t1_valid", 64'(dnValid), 64'd1);
        check("t1_data", 64'(dnData), word(0, 29'h0ABCDEF));
        dnRead = 1'b1;
        seq(33, 33, -1, -1, -1, -1, '0);
        dnRead = 1'b0;
        check("t1_popped", 64'(dnValid), 64'd0);

        // Non-hit L1As still advance the event counter
        doReset();
        seq(0, 29, 12, 12, 29, 29, 29'h1234567);
        seq(30, 30, -1, -1, -1, -1, '0);
        seq(31, 33, -1, -1, 31, 32, '0);
        check("t2_no_push", 64'(dnValid), 64'd0);
        seq(34, 34, -1, -1, -1, -1, '0);
        check("t2_valid", 64'(dnValid), 64'd1);
        check("t2_data", 64'(dnData), word(2, 29'h1234567));
        dnRead = 1'b1;
        seq(35, 35, -1, -1, -1, -1, '0);
        dnRead = 1'b0;

        // Delay 0 reads the entry written a full buffer depth earlier
        L1ADelay = 7'd0;
        doReset();
        seq(0, 4, -1, -1, -1, -1, '0);
        seq(5, 5, 5, 5, 5, 5, 29'h0000555);
        seq(6, 132, -1, -1, -1, -1, '0);
        check("t3_stale_zero", 64'(dnValid), 64'd0);
        seq(133, 134, -1, -1, 133, 133, '0);
        check("t3_not_yet", 64'(dnValid), 64'd0);
        seq(135, 135, -1, -1, -1, -1, '0);
        check("t3_wrap_valid", 64'(dnValid), 64'd1);
        check("t3_wrap_data", 64'(dnData), word(1, 29'h0000555));
        dnRead = 1'b1;
        seq(136, 136, -1, -1, -1, -1, '0);
        dnRead = 1'b0;

        // Six back-to-back hit L1As into a four-deep FIFO
        L1ADelay = 7'd20;
        doReset();
        seq(0, 35, 10, 15, 30, 35, 29'h0000100);
        check("t4_full_at4", 64'(fifoFull), 64'd1);
        check("t4_ovf_at4", 64'(ovfCount), 64'd0);
        seq(36, 37, -1, -1, -1, -1, '0);
        check("t4_ovf", 64'(ovfCount), 64'd2);
        check("t4_full", 64'(fifoFull), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_head%0d", k), 64'(dnData), word(k, 29'h0000100 + 29'(k)));
            dnRead = 1'b1;
            seq(38 + k, 38 + k, -1, -1, -1, -1, '0);
        end
        dnRead = 1'b0;
        check("t4_empty", 64'(dnValid), 64'd0);
        check("t4_not_full", 64'(fifoFull), 64'd0);

        // Push into a full FIFO while popping: no drop
        doReset();
        seq(0, 35, 10, 14, 30, 34, 29'h0000200);
        check("t5_full", 64'(fifoFull), 64'd1);
        dnRead = 1'b1;
        seq(36, 36, -1, -1, -1, -1, '0);
        dnRead = 1'b0;
        check("t5_still_full", 64'(fifoFull), 64'd1);
        check("t5_ovf", 64'(ovfCount), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("t5_head%0d", k), 64'(dnData), word(k, 29'h0000200 + 29'(k)));
            dnRead = 1'b1;
            seq(36 + k, 36 + k, -1, -1, -1, -1, '0);
        end
        dnRead = 1'b0;
        check("t5_empty", 64'(dnValid), 64'd0);

        // Asynchronous reset with words queued, then readout disable
        doReset();
        seq(0, 38, 10, 16, 30, 36, 29'h0000300);
        check("t6_ovf", 64'(ovfCount), 64'd3);
        dnRead = 1'b1;
        seq(39, 39, -1, -1, -1, -1, '0);
        dnRead = 1'b0;
        check("t6_three_left", 64'(dnData), word(1, 29'h0000301));
        check("t6_not_full", 64'(fifoFull), 64'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_async_valid", 64'(dnValid), 64'd0);
        check("t6_async_ovf", 64'(ovfCount), 64'd0);
        check("t6_async_data", 64'(dnData), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        seq(0, 32, 10, 10, 30, 30, 29'h0000777);
        check("t6_evt_restart", 64'(dnData), word(0, 29'h0000777));
        check("t6_valid", 64'(dnValid), 64'd1);
        disDataReadout = 1'b1;
        seq(33, 63, 40, 40, 60, 60, 29'h0000888);
        check("t6_dis_head", 64'(dnData), word(0, 29'h0000777));
        check("t6_dis_ovf", 64'(ovfCount), 64'd0);
        dnRead = 1'b1;
        seq(64, 64, -1, -1, -1, -1, '0);
        dnRead = 1'b0;
        seq(65, 66, -1, -1, -1, -1, '0);
        check("t6_dis_drained", 64'(dnValid), 64'd0);
        disDataReadout = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
